// File: rtl/apb_master_pkg.sv
//------------------------------------------------------------------------------
// Module   : apb_master_pkg
// Purpose  : Shared types and helpers for the APB burst master: access size,
//            FSM state, command control fields, strobe and alignment helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_master_pkg;

    typedef enum logic [1:0] {
        FULLWORD = 2'd0,
        HALFWORD = 2'd1,
        BYTE     = 2'd2,
        RSVD     = 2'd3
    } apb_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic      wr;
        apb_size_e size;
    } cmd_ctrl_t;

    localparam int unsigned WORD_BYTES = 4;

    // Unshifted byte-enable pattern of an access; a word is always 4 bytes.
    function automatic logic [WORD_BYTES-1:0] size_mask(input apb_size_e size);
        case (size)
            FULLWORD: size_mask = 4'b1111;
            HALFWORD: size_mask = 4'b0011;
            BYTE:     size_mask = 4'b0001;
            default:  size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic access_legal(input apb_size_e size, input logic [1:0] addr_lo);
        case (size)
            FULLWORD: access_legal = (addr_lo == 2'b00);
            HALFWORD: access_legal = (addr_lo[0] == 1'b0);
            BYTE:     access_legal = 1'b1;
            default:  access_legal = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
//------------------------------------------------------------------------------
// Module   : apb_cmd_fifo
// Purpose  : Synchronous FIFO holding packed commands, with full/empty flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_burst_master.sv
//------------------------------------------------------------------------------
// Module   : apb_burst_master
// Purpose  : Queues single-beat commands and issues them as back-to-back APB
//            transfers with lane steering, one response per command.
//            Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_burst_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [1:0]                cmd_size,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    output logic                      rsp_wr,
    output logic                      rsp_err,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);

    typedef struct packed {
        cmd_ctrl_t             ctrl;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    cmd_t                  cmd_in;
    cmd_t                  fifo_dout;
    cmd_t                  head;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic                  accept, head_valid, head_legal, pop, start;
    logic [LANE_W-1:0]     head_lane;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [STRB_W-1:0]     head_strb;
    logic [DATA_WIDTH-1:0] rd_shift, rd_mask, rd_data;
    logic [WORD_BYTES-1:0] rd_bytes;

    apb_state_e            state_q, state_d;
    apb_size_e             size_q, size_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  tmo_hit;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        cmd_in           = '0;
        cmd_in.ctrl.wr   = cmd_wr;
        cmd_in.ctrl.size = apb_size_e'(cmd_size);
        cmd_in.addr      = cmd_addr;
        cmd_in.wdata     = cmd_wdata;
    end

    assign cmd_ready = !fifo_full;
    assign accept    = cmd_valid && !fifo_full;

    // An empty FIFO is bypassed so a fresh command reaches SETUP one cycle after acceptance.
    assign head       = fifo_empty ? cmd_in : fifo_dout;
    assign head_valid = !fifo_empty || accept;
    assign head_legal = access_legal(head.ctrl.size, head.addr[1:0]);
    assign fifo_push  = accept && !(fifo_empty && pop);
    assign fifo_pop   = pop && !fifo_empty;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_lane  = head.addr[LANE_W-1:0];
    assign head_wdata = head.wdata << {head_lane, 3'b000};
    assign head_strb  = head.ctrl.wr ? (STRB_W'(size_mask(head.ctrl.size)) << head_lane) : '0;

    assign rd_bytes = size_mask(size_q);
    assign rd_shift = prdata >> {paddr_q[LANE_W-1:0], 3'b000};
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_mask[8*i +: 8] = {8{rd_bytes[i]}};
        end
    end
    assign rd_data = rd_shift & rd_mask;

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = 1'b0;
        rsp_wr_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        pop         = 1'b0;
        start       = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        start = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_wr_d    = head.ctrl.wr;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = pwrite_q;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? rd_data : '0;
                    // Illegal heads are retired from IDLE so they never touch the bus.
                    if (head_valid && head_legal) begin
                        pop   = 1'b1;
                        start = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = pwrite_q;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
`ifdef APB_TIMEOUT_EN
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (start) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = head.addr;
            pwrite_d  = head.ctrl.wr;
            pwdata_d  = head_wdata;
            pstrb_d   = head_strb;
            size_d    = head.ctrl.size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= FULLWORD;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_burst_master.sv
//------------------------------------------------------------------------------
// Module   : tb_apb_burst_master
// Purpose  : Directed self-checking bench for apb_burst_master (32-bit data).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_wr, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_burst_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .CMD_DEPTH  (4),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_size  (cmd_size),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_wr    (rsp_wr),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_pwdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_size  = size;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    // Single command: accept in cycle 0, SETUP cycle 1, ACCESS cycle 2, response cycle 3.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        chk({p, " cmd_ready"}, cmd_ready, 1);
        drive_cmd(v.wr, v.size, v.addr, v.wdata);
        tick();
        cmd_valid = 1'b0;
        chk({p, " setup psel"}, psel, 1);
        chk({p, " setup penable"}, penable, 0);
        chk({p, " paddr"}, paddr, v.addr);
        chk({p, " pwrite"}, pwrite, v.wr);
        chk({p, " pstrb"}, pstrb, v.exp_strb);
        chk({p, " pwdata"}, pwdata, v.exp_pwdata);
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.slverr;
        tick();
        chk({p, " access penable"}, {psel, penable}, 2'b11);
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        chk({p, " rsp_valid"}, rsp_valid, 1);
        chk({p, " rsp_wr"}, rsp_wr, v.wr);
        chk({p, " rsp_err"}, rsp_err, v.exp_err);
        chk({p, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({p, " psel after"}, psel, 0);
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd0, 32'h0F0, 32'h000A3210, 32'h0, 1'b0, 4'hF, 32'h000A3210, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 2'd1, 32'h012, 32'h510FCB29, 32'h0, 1'b0, 4'b1100, 32'hCB290000, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h03D, 32'h0, 32'h00003400, 1'b0, 4'h0, 32'h0, 1'b0, 32'h34};
        vecs[3] = '{1'b1, 2'd2, 32'h003, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5000000, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 2'd1, 32'h020, 32'h0, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 1'b0, 32'hBEEF};
        vecs[5] = '{1'b0, 2'd0, 32'h044, 32'h0, 32'h12345678, 1'b0, 4'h0, 32'h0, 1'b0, 32'h12345678};
        vecs[6] = '{1'b0, 2'd1, 32'h01E, 32'h0, 32'hCAFEF00D, 1'b0, 4'h0, 32'h0, 1'b0, 32'hCAFE};
        vecs[7] = '{1'b1, 2'd2, 32'h001, 32'h123456FF, 32'h0, 1'b0, 4'b0010, 32'h3456FF00, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 2'd0, 32'h200, 32'h11112222, 32'hFFFFFFFF, 1'b1, 4'hF, 32'h11112222, 1'b1, 32'h0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_size  = 2'd0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        chk("reset psel", psel, 0);
        chk("reset penable", penable, 0);
        chk("reset pwrite", pwrite, 0);
        chk("reset pstrb", pstrb, 0);
        chk("reset pwdata", pwdata, 0);
        chk("reset paddr", paddr, 0);
        chk("reset rsp", {rsp_valid, rsp_wr, rsp_err}, 3'b000);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back: eight FULLWORD writes through a four-deep queue.
        begin
            int acc = 0, psel_cyc = 0, rsp_n = 0, rdy_low = 0, gaps = 0, setup_n = 0, bad = 0;
            pready = 1'b1;
            for (int cyc = 0; cyc < 60 && rsp_n < 8; cyc++) begin
                if (acc < 8) drive_cmd(1'b1, 2'd0, 32'h0B0 + 32'(4 * acc), 32'h100 + 32'(acc));
                else cmd_valid = 1'b0;
                if (!cmd_ready) rdy_low++;
                if (psel) begin
                    psel_cyc++;
                    if (!penable) begin
                        chk($sformatf("b2b setup%0d paddr", setup_n), paddr, 32'h0B0 + 32'(4 * setup_n));
                        setup_n++;
                    end
                end else if (setup_n > 0 && setup_n < 8) begin
                    gaps++;
                end
                if (rsp_valid) begin
                    rsp_n++;
                    if (rsp_err || !rsp_wr) bad++;
                end
                if (cmd_valid && cmd_ready) acc++;
                tick();
            end
            cmd_valid = 1'b0;
            pready    = 1'b0;
            chk("b2b accepted", acc, 8);
            chk("b2b responses", rsp_n, 8);
            chk("b2b apb cycles", psel_cyc, 16);
            chk("b2b idle gaps", gaps, 0);
            chk("b2b cmd_ready low seen", rdy_low > 0, 1);
            chk("b2b bad responses", bad, 0);
            tick();
        end

        // Misaligned and reserved-size commands never reach the bus.
        begin
            logic [2:0] exp_wr;
            int rsp_n = 0, psel_n = 0, bad = 0;
            exp_wr = 3'b101;
            for (int cyc = 0; cyc < 8; cyc++) begin
                case (cyc)
                    0: drive_cmd(1'b1, 2'd1, 32'h013, 32'h1);
                    1: drive_cmd(1'b0, 2'd0, 32'h0B2, 32'h2);
                    2: drive_cmd(1'b1, 2'd3, 32'h040, 32'h3);
                    default: cmd_valid = 1'b0;
                endcase
                if (psel) psel_n++;
                if (rsp_valid) begin
                    if (rsp_n != cyc - 1) bad++;
                    if (!rsp_err || rsp_rdata != 0 || (rsp_n < 3 && rsp_wr != exp_wr[rsp_n])) bad++;
                    rsp_n++;
                end
                tick();
            end
            chk("misalign responses", rsp_n, 3);
            chk("misalign psel cycles", psel_n, 0);
            chk("misalign bad responses", bad, 0);
        end

        // Wait states then slave error on a read.
        drive_cmd(1'b0, 2'd0, 32'h100, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("wait setup", {psel, penable}, 2'b10);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wait%0d ctrl", i), {psel, penable, pwrite}, 3'b110);
            chk($sformatf("wait%0d paddr", i), paddr, 32'h100);
            chk($sformatf("wait%0d pstrb", i), pstrb, 0);
            chk($sformatf("wait%0d rsp_valid", i), rsp_valid, 0);
            if (i == 3) begin
                pready  = 1'b1;
                pslverr = 1'b1;
                prdata  = 32'hFFFFFFFF;
            end
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        chk("slverr rsp_valid", rsp_valid, 1);
        chk("slverr rsp_err", rsp_err, 1);
        chk("slverr rsp_rdata", rsp_rdata, 0);
        chk("slverr rsp_wr", rsp_wr, 0);
        tick();

`ifdef APB_TIMEOUT_EN
        begin
            int acc_cyc = 0;
            logic got = 1'b0;
            drive_cmd(1'b0, 2'd0, 32'h500, 32'h0);
            tick();
            cmd_valid = 1'b0;
            for (int cyc = 0; cyc < 60 && !got; cyc++) begin
                if (rsp_valid) begin
                    got = 1'b1;
                    chk("timeout rsp_err", rsp_err, 1);
                    chk("timeout psel dropped", {psel, penable}, 2'b00);
                end else begin
                    if (penable) acc_cyc++;
                    tick();
                end
            end
            chk("timeout response seen", got, 1);
            chk("timeout access cycles", acc_cyc, 16);
            tick();
        end
`endif

        // Reset during ACCESS with a second command queued behind it.
        begin
            int late = 0;
            pready = 1'b0;
            drive_cmd(1'b1, 2'd0, 32'h300, 32'hAAAA5555);
            tick();
            drive_cmd(1'b1, 2'd0, 32'h304, 32'h5555AAAA);
            tick();
            cmd_valid = 1'b0;
            chk("pre-reset access", {psel, penable}, 2'b11);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("mid reset psel", {psel, penable}, 2'b00);
            chk("mid reset cmd_ready", cmd_ready, 1);
            chk("mid reset rsp_valid", rsp_valid, 0);
            for (int cyc = 0; cyc < 6; cyc++) begin
                tick();
                if (rsp_valid || psel) late++;
            end
            chk("post reset activity", late, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_burst_master.md
# apb_burst_master

Parametrised APB master sitting between a command-producing agent and an APB slave port such as the bridge/memory subsystem. Buffers single-beat commands in a FIFO and issues them as back-to-back APB transfers with no IDLE between queued beats. Generates byte strobes and lane-shifted data for FULLWORD/HALFWORD/BYTE accesses, and returns one response per command. Reports slave error, misalignment and optional timeout.

## Interface
- ADDR_WIDTH, 32, APB/command address width
- DATA_WIDTH, 32, APB data width; 32 or 64 only
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT, 16, max ACCESS cycles waiting for pready (used only with APB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_wr  in  1  1 = write, 0 = read
- cmd_size  in  2  0 FULLWORD, 1 HALFWORD, 2 BYTE, 3 reserved
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data, right-justified (LSB-aligned)
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_wr  out  1  direction of the completed command
- rsp_err  out  1  pslverr, misaligned, reserved size or timeout
- rsp_rdata  out  DATA_WIDTH  read data, right-justified, zero-extended; 0 for writes and errors
- paddr  out  ADDR_WIDTH  APB address (as given, not aligned)
- psel, penable, pwrite  out  1 each  APB control
- pwdata  out  DATA_WIDTH  lane-shifted write data
- pstrb  out  DATA_WIDTH/8  byte strobes; all 0 on reads
- prdata  in  DATA_WIDTH  APB read data
- pready, pslverr  in  1 each  APB completion and error

## Operation
- Command accepted when cmd_valid & cmd_ready; pushed into FIFO. cmd_ready = !full, independent of same-cycle pop.
- FSM states IDLE, SETUP, ACCESS.
- IDLE, FIFO non-empty, head legal -> SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb loaded from head; head popped.
- IDLE, head illegal (reserved size, HALFWORD with addr[0]=1, FULLWORD with addr[1:0]≠0) -> pop, error response, stay IDLE; no APB activity.
- SETUP -> ACCESS unconditionally (penable=1).
- ACCESS, pready=1 -> response issued. Go to SETUP if FIFO head legal, else IDLE (an illegal head is handled from IDLE).
- ACCESS, pready=0 -> hold all APB outputs stable.
- Lane n = addr[$clog2(DATA_WIDTH/8)-1:0]. pwdata = cmd_wdata << 8·n; pstrb = size mask (FULLWORD 4'hF, HALFWORD 2'b11, BYTE 1'b1) << n. With DATA_WIDTH=64, FULLWORD at n=4 is legal.
- Read result = (prdata >> 8·n) masked to access size.
- rsp_err on APB completion = pslverr. Read data is forced to 0 when rsp_err=1.

## Timing
- Reset: psel, penable, pwrite, pstrb, pwdata, paddr, rsp_* all 0; cmd_ready=1; FIFO emptied; FSM IDLE. Reset mid-transfer drops psel at the next edge; no response is issued for in-flight or queued commands.
- Cycle 0 accept -> cycle 1 SETUP -> cycle 2 ACCESS. With pready=1 in cycle 2, rsp_valid=1 in cycle 3.
- Back-to-back: a queued next command enters SETUP in cycle 3. Throughput is one beat per 2 cycles with zero wait states.
- Misaligned/reserved command: rsp_valid one cycle after the pop.
- Responses are delivered strictly in command order.

## Configuration
- APB_TIMEOUT_EN defined: a counter resets on entering ACCESS. After TIMEOUT ACCESS cycles with pready=0, the transfer is aborted: psel and penable drop next cycle, rsp_valid=1 with rsp_err=1, then the FSM proceeds as on normal completion.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely. The TIMEOUT parameter is ignored.

## Structure
- Package apb_master_pkg: size enum (FULLWORD, HALFWORD, BYTE, RSVD), FSM state enum, command struct, strobe/alignment-check function.
- Sub-module apb_cmd_fifo: parametrised synchronous FIFO (width = packed command struct, depth CMD_DEPTH) with full/empty outputs.

## Test plan
- Reset and single write: write FULLWORD 0x0F0 data 0x000A3210 -> SETUP at cycle 1, pstrb=4'hF, pwdata=0x000A3210; rsp_valid at cycle 3, rsp_err=0.
- Sub-word lanes: HALFWORD write 0x012 data 0x510FCB29 -> pstrb=4'b1100, pwdata=0xCB290000. BYTE read 0x03D with prdata=0x00003400 -> rsp_rdata=0x34.
- Back-to-back: 8 FULLWORD writes from 0x0B0 queued with FIFO depth 4 -> cmd_ready low while full, 8 responses, no IDLE cycle between beats, 16 APB cycles total.
- Misalignment: HALFWORD at 0x013, then FULLWORD at 0x0B2, then size 3 -> three rsp_err=1 responses, psel never asserted.
- Slave error and wait states: read 0x100, pready low 3 cycles, then pslverr=1 -> outputs stable while waiting; rsp_err=1, rsp_rdata=0.
- Timeout and reset: with APB_TIMEOUT_EN and TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1. Assert rst during ACCESS -> psel=0 and cmd_ready=1 next cycle, no response.
